// File: rtl/cl_seq.sv
// Bit-serial sequencer for the shared 1-bit logic cell: shifts an operand pair through the cell
// LSB first, assembles the N-bit result and pulses done for one cycle.
module cl_seq #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   s,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         zero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [1:0]     s_q, s_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   res_sh_q, res_sh_d;
  logic [N-1:0]   out_q, out_d;
  logic           zero_q, zero_d;
  logic           cell_out;
  logic [N-1:0]   res_next;

  // The shared logic cell.
  always_comb begin
    cell_out = 1'b0;
    case (s_q)
      2'b00:   cell_out = a_sh_q[0] & b_sh_q[0];
      2'b01:   cell_out = a_sh_q[0] | b_sh_q[0];
      2'b10:   cell_out = a_sh_q[0] ^ b_sh_q[0];
      default: cell_out = ~a_sh_q[0];
    endcase
  end

  assign res_next = {cell_out, res_sh_q[N-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    res_sh_d = res_sh_q;
    out_d    = out_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          s_d      = s;
          cnt_d    = '0;
          res_sh_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        res_sh_d = res_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          out_d   = res_next;
          zero_d  = (res_next == '0);
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      res_sh_q <= '0;
      out_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      res_sh_q <= res_sh_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign out  = out_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_cl_seq.sv
// Randomised self-checking bench for cl_seq at N=4 (directed), N=2 and N=16 (random sweep),
// against a word-level reference of the four logic functions.
module tb_cl_seq;

  logic        clk;
  logic        reset;
  logic        start_v [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic [1:0]  s_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        zero_v  [3];
  logic [15:0] out_v   [3];
  logic [3:0]  out4;
  logic [1:0]  out2;
  logic [15:0] out16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_done_cyc;

  cl_seq #(.N(4)) u_n4 (
    .clk(clk), .reset(reset), .start(start_v[0]), .a(a_v[0][3:0]), .b(b_v[0][3:0]),
    .s(s_v[0]), .busy(busy_v[0]), .done(done_v[0]), .out(out4), .zero(zero_v[0])
  );
  cl_seq #(.N(2)) u_n2 (
    .clk(clk), .reset(reset), .start(start_v[1]), .a(a_v[1][1:0]), .b(b_v[1][1:0]),
    .s(s_v[1]), .busy(busy_v[1]), .done(done_v[1]), .out(out2), .zero(zero_v[1])
  );
  cl_seq #(.N(16)) u_n16 (
    .clk(clk), .reset(reset), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .s(s_v[2]), .busy(busy_v[2]), .done(done_v[2]), .out(out16), .zero(zero_v[2])
  );

  always_comb begin
    out_v[0] = {12'b0, out4};
    out_v[1] = {14'b0, out2};
    out_v[2] = out16;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input int n, input logic [15:0] av, input logic [15:0] bv,
                                         input logic [1:0] sv);
    logic [15:0] r;
    logic [15:0] mask;
    mask = 16'((32'd1 << n) - 1);
    case (sv)
      2'b00:   r = av & bv;
      2'b01:   r = av | bv;
      2'b10:   r = av ^ bv;
      default: r = ~av;
    endcase
    return r & mask;
  endfunction

  // Caller is at the negedge after the accepting edge; scrambles a/b/s while waiting.
  task automatic wait_done(input int k, output int edges);
    edges = 1;
    while (!done_v[k] && edges < 64) begin
      chk("busy_run", busy_v[k], 1);
      @(posedge clk);
      edges++;
      @(negedge clk);
      a_v[k] = 16'($urandom);
      b_v[k] = 16'($urandom);
      s_v[k] = 2'($urandom);
    end
  endtask

  // Called and returns at a negedge with the DUT idle.
  task automatic do_op(input int k, input int n, input logic [15:0] av, input logic [15:0] bv,
                       input logic [1:0] sv, input string tag);
    int edges;
    logic [15:0] exp;
    exp = ref_op(n, av, bv, sv);
    start_v[k] = 1'b1;
    a_v[k] = av;
    b_v[k] = bv;
    s_v[k] = sv;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    wait_done(k, edges);
    last_done_cyc = cyc;
    chk({tag, "_lat"}, edges, n + 1);
    chk({tag, "_out"}, out_v[k], exp);
    chk({tag, "_zero"}, zero_v[k], exp == 0);
    chk({tag, "_busy_done"}, busy_v[k], 1);
    @(negedge clk);
    chk({tag, "_done_once"}, done_v[k], 0);
    chk({tag, "_busy_idle"}, busy_v[k], 0);
    chk({tag, "_out_hold"}, out_v[k], exp);
  endtask

  initial begin
    int c1;
    int edges;
    int dcount;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      a_v[i] = '0;
      b_v[i] = '0;
      s_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy", busy_v[0], 0);
      chk("idle_done", done_v[0], 0);
      chk("idle_out", out_v[0], 0);
      chk("idle_zero", zero_v[0], 0);
    end

    do_op(0, 4, 16'b1100, 16'b1010, 2'b00, "and");
    do_op(0, 4, 16'b1100, 16'b1010, 2'b01, "or");
    do_op(0, 4, 16'b1100, 16'b1010, 2'b10, "xor");
    do_op(0, 4, 16'b1100, 16'b1010, 2'b11, "not");
    chk("not_literal", out_v[0], 16'b0011);

    do_op(0, 4, 16'b0101, 16'b1010, 2'b00, "zero_and");
    c1 = last_done_cyc;
    do_op(0, 4, 16'b0011, 16'b0101, 2'b01, "b2b");
    chk("b2b_interval", last_done_cyc - c1, 6);

    // Start held high through the whole operation.
    start_v[0] = 1'b1;
    a_v[0] = 16'b1111;
    b_v[0] = 16'b0000;
    s_v[0] = 2'b01;
    @(posedge clk);
    @(negedge clk);
    wait_done(0, edges);
    chk("hold_lat", edges, 5);
    chk("hold_out", out_v[0], 16'b1111);
    chk("hold_zero", zero_v[0], 0);
    @(negedge clk);
    chk("hold_idle_busy", busy_v[0], 0);
    chk("hold_idle_done", done_v[0], 0);
    a_v[0] = 16'b1001;
    b_v[0] = 16'b0011;
    s_v[0] = 2'b10;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("hold_reaccept", busy_v[0], 1);
    wait_done(0, edges);
    chk("hold2_lat", edges, 5);
    chk("hold2_out", out_v[0], 16'b1010);
    @(negedge clk);

    // Reset in the middle of an operation.
    start_v[0] = 1'b1;
    a_v[0] = 16'b1111;
    b_v[0] = 16'b1111;
    s_v[0] = 2'b01;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_out", out_v[0], 0);
    chk("rst_zero", zero_v[0], 0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    chk("rst_no_done", dcount, 0);
    do_op(0, 4, 16'b0011, 16'b0101, 2'b10, "post_rst");

    for (int i = 0; i < 20; i++) begin
      do_op(1, 2, 16'($urandom), 16'($urandom), 2'($urandom), "n2");
      do_op(2, 16, 16'($urandom), 16'($urandom), 2'($urandom), "n16");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
